// File: rtl/ram_stream_reader.sv
// Burst reader: turns an (address, length) command into a valid/ready word stream
// from a RAM with a registered read port, tagging the final word with out_last.
module ram_stream_reader #(
   parameter int ADDR_SIZE = 11,
   parameter int DATA_SIZE = 9
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [ADDR_SIZE-1:0] cmd_addr,
   input  logic [ADDR_SIZE:0]   cmd_len,
   output logic [ADDR_SIZE-1:0] r_addr,
   input  logic [DATA_SIZE-1:0] mem_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 out_last,
   output logic                 busy
);

   // A read takes two edges (r_addr register, then RAM output register) before
   // capture, so a third slot is needed to stream one word per cycle without
   // ever overflowing when the sink stalls.
   localparam int DEPTH = 3;
   localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_SIZE:0]   LEN_ONE  = 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                 state, state_nx;
   logic [ADDR_SIZE-1:0]   addr_q;
   logic [ADDR_SIZE:0]     remaining;
   logic [2:1]             vld_pipe;
   logic [2:1]             last_pipe;
   logic                   issue, issue_last, push, pop;
   logic [ADDR_SIZE-1:0]   issue_addr;
   logic [2:0]             credit_use;

   logic [DATA_SIZE-1:0]   buf_data [DEPTH];
   logic                   buf_last [DEPTH];
   logic [1:0]             head, tail, count;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign out_valid  = (count != 2'd0);
   assign out_data   = out_valid ? buf_data[head] : '0;
   assign out_last   = out_valid && buf_last[head];
   assign pop        = out_valid && out_ready;
   assign push       = vld_pipe[2];
   assign cmd_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign credit_use = {1'b0, count} + {2'b0, vld_pipe[1]} + {2'b0, vld_pipe[2]}
                       - {2'b0, pop};

   // The first read goes out on the accept edge so r_addr = cmd_addr right away.
   always_comb begin
      state_nx   = state;
      issue      = 1'b0;
      issue_addr = addr_q;
      issue_last = (remaining == LEN_ONE);
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_len != '0) begin
               issue      = 1'b1;
               issue_addr = cmd_addr;
               issue_last = (cmd_len == LEN_ONE);
               state_nx   = READ;
            end
         end
         READ: begin
            if (remaining == '0) state_nx = DRAIN;
            else if (credit_use < 3'(DEPTH)) issue = 1'b1;
         end
         DRAIN: begin
            if (vld_pipe == 2'b00 && (count == 2'd0 || (count == 2'd1 && pop)))
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         remaining <= '0;
         r_addr    <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
      end else begin
         state     <= state_nx;
         vld_pipe  <= {vld_pipe[1], issue};
         last_pipe <= {last_pipe[1], issue && issue_last};
         if (issue) begin
            r_addr    <= issue_addr;
            addr_q    <= issue_addr + ADDR_ONE;
            remaining <= ((state == IDLE) ? cmd_len : remaining) - LEN_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_data[i] <= '0;
            buf_last[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            buf_data[tail] <= mem_data;
            buf_last[tail] <= last_pipe[2];
            tail           <= ptr_inc(tail);
         end
         if (pop) head <= ptr_inc(head);
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a registered-read RAM model holding
// mem[i] = i mod 512.
module tb_ram_stream_reader;
   localparam int AW = 11;
   localparam int DW = 9;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [AW:0]   cmd_len;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] mem_data;
   logic          out_valid, out_ready, out_last, busy;
   logic [DW-1:0] out_data;

   logic [DW-1:0] mem [2**AW];
   int n_cmp = 0;
   int n_bad = 0;
   logic [5:0] pat = 6'b101001; // ready sequence 1,0,0,1,0,1 read from bit 0

   ram_stream_reader #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .r_addr(r_addr), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) mem_data <= mem[r_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] word_at(input int a);
      return DW'((a % (2**AW)) % (2**DW));
   endfunction

   // One cycle: packed {out_valid, out_last, cmd_ready, out_data}
   task automatic step(input string tag, input logic v, input int d, input logic l,
                       input logic cr);
      @(negedge clk);
      chk(tag, {20'd0, out_valid, out_last, cmd_ready, out_data},
          {20'd0, v, l, cr, word_at(d)});
   endtask

   task automatic send_cmd(input string tag, input int a, input int len);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = AW'(a); cmd_len = (AW+1)'(len);
      chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (len != 0) begin
         chk({tag, "_busy"}, {30'd0, busy, cmd_ready}, 32'b10);
         chk({tag, "_raddr"}, 32'(r_addr), 32'(a));
      end
   endtask

   // Pops n words, checking order, last tag and hold-while-stalled
   task automatic collect(input string tag, input int a0, input int n, input bit toggle);
      int k = 0;
      int cyc = 0;
      bit stall = 1'b0;
      logic [DW-1:0] pd = '0;
      logic pl = 1'b0;
      while (k < n && cyc < 60) begin
         @(negedge clk);
         out_ready = toggle ? pat[cyc % 6] : 1'b1;
         if (stall)
            chk({tag, "_hold"}, {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, pl, pd});
         if (out_valid && out_ready) begin
            chk({tag, "_data"}, 32'(out_data), 32'(word_at(a0 + k)));
            chk({tag, "_last"}, 32'(out_last), 32'(k == n - 1));
            k++;
         end
         stall = out_valid && !out_ready;
         pd = out_data;
         pl = out_last;
         cyc++;
      end
      chk({tag, "_count"}, 32'(k), 32'(n));
      @(negedge clk);
      out_ready = 1'b1;
      chk({tag, "_end"}, {29'd0, out_valid, cmd_ready, busy}, 32'b010);
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
      #12;
      chk("rst_ctl", {28'd0, cmd_ready, busy, out_valid, out_last}, 32'b1000);
      chk("rst_raddr", 32'(r_addr), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Full-rate burst: first word three cycles after accept
      send_cmd("b4", 5, 4);
      step("b4_e1", 1'b0, 0, 1'b0, 1'b0);
      step("b4_e2", 1'b1, 5, 1'b0, 1'b0);
      step("b4_e3", 1'b1, 6, 1'b0, 1'b0);
      step("b4_e4", 1'b1, 7, 1'b0, 1'b0);
      step("b4_e5", 1'b1, 8, 1'b1, 1'b0);
      step("b4_e6", 1'b0, 0, 1'b0, 1'b1);

      // Backpressure
      send_cmd("bp", 5, 4);
      collect("bp", 5, 4, 1'b1);

      // Address wrap
      send_cmd("wrap", 2046, 4);
      collect("wrap", 2046, 4, 1'b0);

      // Zero length
      send_cmd("zero", 50, 0);
      chk("zero_idle", {29'd0, cmd_ready, busy, out_valid}, 32'b100);
      step("zero_n1", 1'b0, 0, 1'b0, 1'b1);
      step("zero_n2", 1'b0, 0, 1'b0, 1'b1);

      // Back-to-back with cmd_valid held while busy
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = AW'(5); cmd_len = (AW+1)'(2);
      @(negedge clk);
      cmd_addr = AW'(100); cmd_len = (AW+1)'(3);
      chk("b2b_raddr0", 32'(r_addr), 32'd5);
      step("b2b_e1", 1'b0, 0, 1'b0, 1'b0);
      step("b2b_e2", 1'b1, 5, 1'b0, 1'b0);
      step("b2b_e3", 1'b1, 6, 1'b1, 1'b0);
      chk("b2b_noacc", 32'(r_addr), 32'd6);
      step("b2b_e4", 1'b0, 0, 1'b0, 1'b1);
      step("b2b_e5", 1'b0, 0, 1'b0, 1'b0);
      cmd_valid = 1'b0;
      chk("b2b_raddr1", 32'(r_addr), 32'd100);
      step("b2b_e6", 1'b0, 0, 1'b0, 1'b0);
      step("b2b_e7", 1'b1, 100, 1'b0, 1'b0);
      step("b2b_e8", 1'b1, 101, 1'b0, 1'b0);
      step("b2b_e9", 1'b1, 102, 1'b1, 1'b0);
      step("b2b_e10", 1'b0, 0, 1'b0, 1'b1);

      // Reset mid-burst with the buffer full
      out_ready = 1'b0;
      send_cmd("mrst", 20, 10);
      repeat (4) @(negedge clk);
      chk("mrst_full", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_ctl", {28'd0, cmd_ready, busy, out_valid, out_last}, 32'b1000);
      chk("mrst_raddr", 32'(r_addr), 32'd0);
      chk("mrst_data", 32'(out_data), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      out_ready = 1'b1;
      step("mrst_q1", 1'b0, 0, 1'b0, 1'b1);
      step("mrst_q2", 1'b0, 0, 1'b0, 1'b1);
      step("mrst_q3", 1'b0, 0, 1'b0, 1'b1);
      send_cmd("post", 300, 3);
      collect("post", 300, 3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
